m_cp0: RTL and testbench
========================

// Module: m_cp0
// PURPOSE
//  Coprocessor-0 exception/interrupt controller at the M stage. It is the requester side of
//  the fetch-stage redirect: it raises `req` so the PC register loads the exception entrance.
//  It owns SR/Cause/EPC and serves mtc0/mfc0 for pipeline stages.
//  It supplies EPC for eret and captures the victim PC, branch-delay flag and ExcCode.
// PARAMETERS
//  EXC_ENTRANCE  32'h0000_4180  handler address; also driven on exc_entrance
//  IM_MSB/IM_LSB 15/10          interrupt-mask / pending field position in SR and Cause
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-low reset
//  en           in   1   mtc0 write strobe (M-stage instruction is mtc0)
//  cp0_addr     in   5   CP0 register number for mtc0/mfc0
//  cp0_wdata    in   32  mtc0 write data
//  cp0_rdata    out  32  mfc0 read data (combinational)
//  vpc          in   32  PC of the M-stage (victim) instruction
//  bd_in        in   1   victim sits in a branch delay slot
//  exc_code_in  in   5   synchronous ExcCode from the pipeline; 0 = none
//  eret         in   1   M-stage instruction is eret
//  hw_int       in   6   external interrupt lines, level-sensitive
//  req          out  1   exception/interrupt request to PC and flush logic (combinational)
//  epc_out      out  32  EPC value for the eret redirect
//  exc_entrance out  32  constant EXC_ENTRANCE
// BEHAVIOUR
//  Registers: SR(12) = {IM[15:10], EXL[1], IE[0]}; Cause(13) = {BD[31], IP[15:10], ExcCode[6:2]}; EPC(14).
//   All other bits read 0.
//  Reset (reset==0, async): SR, Cause and EPC = 0. While reset is asserted, req is forced to 0.
//  int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL;  exc_req = (exc_code_in!=0) & ~SR.EXL.
//  req = int_req | exc_req. It is combinational, so the PC redirects on the same edge.
//  Each posedge, Cause.IP <= hw_int unconditionally, including during a req cycle.
//  On a posedge with req=1:
//   - EXL <= 1
//   - BD <= bd_in
//   - ExcCode <= int_req ? 0 : exc_code_in; interrupt beats exception
//   - EPC <= bd_in ? vpc-32'd4 : vpc; 32-bit wrap, no alignment
//  req=1 suppresses en and eret that cycle: the victim does not commit.
//  On eret=1 with req=0: EXL <= 0 on the edge.
//   - epc_out = (en && cp0_addr==14) ? cp0_wdata : EPC; bypass of a same-cycle EPC write.
//  mtc0 (en=1, req=0):
//   - addr 12 writes IM, EXL and IE
//   - addr 14 writes EPC
//   - addr 13 and other addresses are ignored (Cause is read-only)
//  en and eret asserted together is illegal; en is then ignored and the bench flags it.
//  mfc0: cp0_rdata returns the register state before the edge (no write-through), 0 for unmapped addresses.
//  With EXL=1, new exceptions and interrupts are masked; nesting is not supported.
//  Reset asserted mid-handler clears EXL and EPC immediately (async).
// STRUCTURE
//  The shared macro header holds:
//   - CP0 register numbers SR=12, Cause=13, EPC=14
//   - field bit positions
//   - ExcCode constants: Int=0, AdEL=4, AdES=5, RI=10, Ov=12
//   - exception entrance / instruction start addresses, shared with the PC register
//  Single module, no sub-module; request logic and the register file together are ~150 lines.
// TESTING
//  Reset: reset=0 while exc_code_in=10 -> req=0, all reads 0. Release -> req=1, ExcCode=10 after the edge.
//  Interrupt: SR=0x0000_0401 via mtc0, hw_int=6'b000001
//   -> req=1; after the edge EXL=1, Cause=0x0000_0400, EPC=vpc.
//  Delay slot: exc_code_in=12, bd_in=1, vpc=0x3010 -> EPC=0x300C, Cause[31]=1, Cause[6:2]=12.
//  Priority and masking:
//   - int plus exc_code_in=4 in the same cycle -> ExcCode=0
//   - with EXL=1, exc_code_in=10 -> req=0
//  eret: EXL=1, EPC=0x3008, eret=1 -> epc_out=0x3008, EXL=0 after the edge.
//   - mtc0 to 14 with 0x3020 in the same cycle -> epc_out=0x3020
//  mtc0 suppression: en=1, addr=12, wdata=0xFFFF_FFFF while exc_req=1 -> SR unchanged except EXL=1.

Source files
------------

// File: rtl/m_cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions, ExcCode values
// and the fixed redirect addresses also used by the PC register.
package m_cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] RegSr    = 5'd12;
  localparam logic [4:0] RegCause = 5'd13;
  localparam logic [4:0] RegEpc   = 5'd14;

  // Field bit positions
  localparam int unsigned SrIeBit       = 0;
  localparam int unsigned SrExlBit      = 1;
  localparam int unsigned CauseBdBit    = 31;
  localparam int unsigned CauseExcMsb   = 6;
  localparam int unsigned CauseExcLsb   = 2;
  localparam int unsigned ImMsbDefault  = 15;
  localparam int unsigned ImLsbDefault  = 10;

  // ExcCode values
  localparam logic [4:0] ExcInt  = 5'd0;
  localparam logic [4:0] ExcAdEL = 5'd4;
  localparam logic [4:0] ExcAdES = 5'd5;
  localparam logic [4:0] ExcRi   = 5'd10;
  localparam logic [4:0] ExcOv   = 5'd12;

  // Redirect targets shared with the PC register
  localparam logic [31:0] ExcEntrance = 32'h0000_4180;
  localparam logic [31:0] InstrStart  = 32'h0000_3000;

endpackage

// File: rtl/m_cp0.sv
// M-stage coprocessor 0: exception/interrupt request generation plus the
// SR/Cause/EPC register file.
//  clk, reset (async, active low)
//  en/cp0_addr/cp0_wdata : mtc0 write port; cp0_rdata : mfc0 read (combinational)
//  vpc, bd_in, exc_code_in : victim instruction info; hw_int : interrupt lines
//  eret : return from handler; epc_out : eret target
//  req : combinational redirect request; exc_entrance : handler address
module m_cp0
  import m_cp0_pkg::*;
#(
  parameter logic [31:0] EXC_ENTRANCE = ExcEntrance,
  parameter int unsigned IM_MSB       = ImMsbDefault,
  parameter int unsigned IM_LSB       = ImLsbDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  output logic        req,
  output logic [31:0] epc_out,
  output logic [31:0] exc_entrance
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  assign int_req = (|(hw_int & im_q)) & ie_q & ~exl_q;
  assign exc_req = (exc_code_in != 5'd0) & ~exl_q;
  // Held low during reset so no redirect escapes while state is being cleared.
  assign req     = reset & (int_req | exc_req);

  assign exc_entrance = EXC_ENTRANCE;
  // Same-cycle EPC write is forwarded so eret sees the value being written.
  assign epc_out = (en && (cp0_addr == RegEpc)) ? cp0_wdata : epc_q;

  always_comb begin
    sr_word                  = '0;
    sr_word[IM_MSB:IM_LSB]   = im_q;
    sr_word[SrExlBit]        = exl_q;
    sr_word[SrIeBit]         = ie_q;
    cause_word                           = '0;
    cause_word[CauseBdBit]               = bd_q;
    cause_word[IM_MSB:IM_LSB]            = ip_q;
    cause_word[CauseExcMsb:CauseExcLsb]  = exc_code_q;
  end

  always_comb begin
    case (cp0_addr)
      RegSr:    cp0_rdata = sr_word;
      RegCause: cp0_rdata = cause_word;
      RegEpc:   cp0_rdata = epc_q;
      default:  cp0_rdata = '0;
    endcase
  end

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = hw_int;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (req) begin
      // Victim does not commit: its mtc0/eret are dropped.
      exl_d      = 1'b1;
      bd_d       = bd_in;
      exc_code_d = int_req ? ExcInt : exc_code_in;
      epc_d      = bd_in ? (vpc - 32'd4) : vpc;
    end else if (eret) begin
      // Takes precedence over a simultaneous (illegal) en.
      exl_d = 1'b0;
    end else if (en) begin
      case (cp0_addr)
        RegSr: begin
          im_d  = cp0_wdata[IM_MSB:IM_LSB];
          exl_d = cp0_wdata[SrExlBit];
          ie_d  = cp0_wdata[SrIeBit];
        end
        RegEpc:  epc_d = cp0_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

endmodule

// File: tb/tb_m_cp0.sv
// Directed bench for m_cp0 with hand-computed expectations.
module tb_m_cp0;

  logic        clk;
  logic        reset;
  logic        en;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic        eret;
  logic [5:0]  hw_int;
  logic        req;
  logic [31:0] epc_out;
  logic [31:0] exc_entrance;

  int n_checks = 0;
  int n_fail   = 0;

  m_cp0 dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .cp0_addr     (cp0_addr),
    .cp0_wdata    (cp0_wdata),
    .cp0_rdata    (cp0_rdata),
    .vpc          (vpc),
    .bd_in        (bd_in),
    .exc_code_in  (exc_code_in),
    .eret         (eret),
    .hw_int       (hw_int),
    .req          (req),
    .epc_out      (epc_out),
    .exc_entrance (exc_entrance)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] addr, input logic [31:0] exp, input string tag);
    cp0_addr = addr;
    #1;
    check_eq(tag, cp0_rdata, exp);
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    en = 1'b1; cp0_addr = addr; cp0_wdata = data;
    step();
    en = 1'b0;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; cp0_addr = '0; cp0_wdata = '0; vpc = 32'h0000_3000;
    bd_in = 1'b0; exc_code_in = 5'd10; eret = 1'b0; hw_int = '0;
    #1;
    // Reset holds req low despite a pending exception
    check_eq("rst_req", {31'd0, req}, 32'd0);
    check_eq("entrance", exc_entrance, 32'h0000_4180);
    step();
    check_eq("rst_req_edge", {31'd0, req}, 32'd0);
    rd(5'd12, 32'd0, "rst_sr");
    rd(5'd13, 32'd0, "rst_cause");
    rd(5'd14, 32'd0, "rst_epc");

    // Release: RI exception fires immediately
    reset = 1'b1;
    #1;
    check_eq("rel_req", {31'd0, req}, 32'd1);
    step();
    rd(5'd12, 32'h0000_0002, "rel_sr");
    rd(5'd13, 32'h0000_0028, "rel_cause");
    rd(5'd14, 32'h0000_3000, "rel_epc");
    // EXL masks further exceptions
    check_eq("exl_mask", {31'd0, req}, 32'd0);

    // eret path
    exc_code_in = 5'd0;
    mtc0(5'd14, 32'h0000_3008);
    rd(5'd14, 32'h0000_3008, "epc_wr");
    eret = 1'b1;
    #1;
    check_eq("eret_epc", epc_out, 32'h0000_3008);
    $display("note: en with eret is illegal; en expected to be ignored");
    en = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_3020;
    #1;
    check_eq("eret_bypass", epc_out, 32'h0000_3020);
    step();
    en = 1'b0; eret = 1'b0;
    rd(5'd12, 32'h0000_0000, "eret_sr");
    rd(5'd14, 32'h0000_3008, "eret_en_ign");

    // Interrupt
    mtc0(5'd12, 32'h0000_0401);
    rd(5'd12, 32'h0000_0401, "sr_wr");
    hw_int = 6'b000001; vpc = 32'h0000_3040;
    #1;
    check_eq("int_req", {31'd0, req}, 32'd1);
    step();
    rd(5'd12, 32'h0000_0403, "int_sr");
    rd(5'd13, 32'h0000_0400, "int_cause");
    rd(5'd14, 32'h0000_3040, "int_epc");
    check_eq("int_masked", {31'd0, req}, 32'd0);

    // Interrupt beats exception
    hw_int = 6'b000000;
    mtc0(5'd12, 32'h0000_0401);
    hw_int = 6'b000011; exc_code_in = 5'd4; vpc = 32'h0000_3050;
    #1;
    check_eq("prio_req", {31'd0, req}, 32'd1);
    step();
    rd(5'd13, 32'h0000_0C00, "prio_cause");
    rd(5'd14, 32'h0000_3050, "prio_epc");

    // Delay-slot exception
    hw_int = 6'b000000; exc_code_in = 5'd0;
    mtc0(5'd12, 32'h0000_0401);
    exc_code_in = 5'd12; bd_in = 1'b1; vpc = 32'h0000_3010;
    #1;
    check_eq("bd_req", {31'd0, req}, 32'd1);
    step();
    rd(5'd14, 32'h0000_300C, "bd_epc");
    rd(5'd13, 32'h8000_0030, "bd_cause");
    rd(5'd12, 32'h0000_0403, "bd_sr");

    // mtc0 suppressed by a same-cycle exception
    exc_code_in = 5'd0; bd_in = 1'b0;
    mtc0(5'd12, 32'h0000_0401);
    exc_code_in = 5'd5; vpc = 32'h0000_3060;
    en = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'hFFFF_FFFF;
    step();
    en = 1'b0; exc_code_in = 5'd0;
    rd(5'd12, 32'h0000_0403, "supp_sr");
    rd(5'd13, 32'h0000_0014, "supp_cause");
    rd(5'd14, 32'h0000_3060, "supp_epc");

    // mfc0 shows pre-edge state
    en = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_1234;
    #1;
    check_eq("no_wthru", cp0_rdata, 32'h0000_3060);
    step();
    check_eq("epc_after", cp0_rdata, 32'h0000_1234);
    en = 1'b0;

    // Cause is read-only, unmapped reads zero
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, 32'h0000_0014, "cause_ro");
    rd(5'd5, 32'h0000_0000, "unmapped");

    // Asynchronous reset mid-handler
    exc_code_in = 5'd10;
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_req", {31'd0, req}, 32'd0);
    rd(5'd12, 32'h0000_0000, "arst_sr");
    rd(5'd14, 32'h0000_0000, "arst_epc");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
